if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch stage of the CPU: owns the program counter, drives the instruction
//   memory read address, and registers the fetched word into the IF/ID pipeline register.
//   Sits upstream of decode/register-file read; honours start gating, decode stalls, and
//   branch/jump redirects from downstream. Stops fetching cleanly when PC leaves program space.
// PARAMETERS
//   PC_W        32    width of PC, addresses and instruction words
//   RESET_PC    0     byte address loaded into PC on reset
//   IMEM_WORDS  256   instruction memory depth in 32-bit words; program space = [0, IMEM_WORDS*4)
// PORTS
//   clk_i            in   1     clock
//   rst_i            in   1     asynchronous reset, active-high
//   start_i          in   1     run enable; low holds the stage idle
//   stall_i          in   1     decode hazard: hold PC and IF/ID contents
//   redirect_i       in   1     taken branch/jump resolved downstream
//   redirect_pc_i    in   PC_W  redirect target byte address
//   imem_addr_o      out  PC_W  instruction memory byte address (= current PC)
//   imem_data_i      in   PC_W  instruction word, combinational read of imem_addr_o
//   pc_o             out  PC_W  current PC
//   if_id_pc4_o      out  PC_W  PC+4 of the instruction held in IF/ID
//   if_id_inst_o     out  PC_W  instruction held in IF/ID
//   if_id_valid_o    out  1     IF/ID holds a real instruction (0 = bubble)
//   halted_o         out  1     PC left program space; fetch stopped
//   fetch_count_o    out  PC_W  number of instructions accepted into IF/ID
// BEHAVIOUR
//   Reset (async, rst_i=1): PC=RESET_PC, state IDLE, if_id_inst_o=0 (NOP), if_id_pc4_o=0,
//     if_id_valid_o=0, halted_o=0, fetch_count_o=0. imem_addr_o follows PC at all times.
//   FSM states IDLE, RUN, HALT:
//     IDLE: no PC update, IF/ID loads bubble. start_i=1 -> RUN on next edge (first fetch
//       captured on that same edge, i.e. 1-cycle latency start->valid).
//     RUN: per cycle, priority redirect_i > stall_i > normal:
//       redirect_i: PC <= {redirect_pc_i[PC_W-1:2],2'b00}; IF/ID <= bubble (flush); count unchanged.
//       stall_i (no redirect): PC, IF/ID, count hold.
//       normal: IF/ID <= {PC+4, imem_data_i, valid=1}; PC <= PC+4; count <= count+1.
//       start_i=0 in RUN -> IDLE; PC retained, IF/ID loads bubble (unless stall_i: hold).
//       PC >= IMEM_WORDS*4 at a normal fetch: no capture, IF/ID <= bubble, -> HALT.
//     HALT: halted_o=1, PC frozen, IF/ID bubble. Only redirect_i into program space exits
//       to RUN (PC loaded, IF/ID bubble); redirect outside program space stays HALT.
//   PC+4 wraps modulo 2**PC_W; fetch_count_o wraps modulo 2**PC_W.
//   Misaligned redirect targets are force-aligned (low 2 bits cleared), never trapped.
//   Redirect and stall same cycle: redirect wins, stall ignored.
//   Reset mid-run: immediate asynchronous return to reset values; no partial IF/ID update.
//   Bubble = {pc4=0, inst=0, valid=0}; inst 0 decodes as sll $0,$0,0 (architectural NOP).
// STRUCTURE
//   Shared package cpu_pkg: NOP_INST (32'h0), fetch FSM state enum, PC_STEP (4).
//   One sub-module: if_pc_reg (PC register with async reset, load/hold/increment select).
//   IF/ID register and FSM stay in this module.
// TESTING
//   1 Reset, start_i=1, imem words 0..3 = 0x20080005,0x20090003,0x01095020,0 -> IF/ID
//     shows each with pc4 = 4,8,12,16 on successive cycles; fetch_count_o = 4 after 4 fetches.
//   2 stall_i high 2 cycles at PC=8 -> pc_o stays 8, IF/ID holds inst@4, count frozen;
//     release -> inst@8 captured next edge.
//   3 redirect_i with stall_i same cycle, redirect_pc_i=0x21 -> PC=0x20, IF/ID bubble,
//     next cycle inst@0x20 valid.
//   4 IMEM_WORDS=4, run sequential -> at PC=16 halted_o=1, valid=0, PC held 16;
//     redirect to 0 -> RUN resumes; redirect to 0x40 while halted -> stays HALT.
//   5 start_i dropped at PC=12 for 3 cycles -> PC holds 12, bubbles; restore -> inst@12 fetched.
//   6 rst_i asserted mid-cycle between edges -> outputs reset immediately, PC=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural NOP, PC step, and the fetch-stage
// state and IF/ID update encodings.
package cpu_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int          PC_STEP  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_BUBBLE,
    IFID_HOLD,
    IFID_LOAD
  } ifid_op_t;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: asynchronous reset, with a select among load,
// increment and hold. Also exports the sequential successor PC.
module if_pc_reg
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            incr,
  input  logic [PC_W-1:0] load_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4
);

  // Wraps modulo 2**PC_W by construction.
  assign pc_plus4 = pc + PC_W'(PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (incr) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address, and registers fetched words into IF/ID under start/stall/redirect.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              IMEM_WORDS = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [PC_W-1:0] imem_data_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] if_id_pc4_o,
  output logic [PC_W-1:0] if_id_inst_o,
  output logic            if_id_valid_o,
  output logic            halted_o,
  output logic [PC_W-1:0] fetch_count_o
);

  // One extra bit so the end of program space is representable at full PC_W.
  localparam logic [PC_W:0] PROG_END = (PC_W+1)'(longint'(IMEM_WORDS) * 64'd4);

  fetch_state_t    state;
  fetch_state_t    state_next;
  ifid_op_t        ifid_op;
  logic            pc_load;
  logic            pc_incr;
  logic            count_inc;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_tgt;
  logic            pc_in_space;
  logic            tgt_in_space;
  logic            unused_redirect_low;

  // Misaligned targets are silently aligned; the discarded bits are unused.
  assign redirect_tgt        = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc_i[1:0];
  assign pc_in_space         = {1'b0, pc} < PROG_END;
  assign tgt_in_space        = {1'b0, redirect_tgt} < PROG_END;

  if_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (pc_load),
    .incr     (pc_incr),
    .load_pc  (redirect_tgt),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ifid_op    = IFID_BUBBLE;
    pc_load    = 1'b0;
    pc_incr    = 1'b0;
    count_inc  = 1'b0;
    unique case (state)
      ST_IDLE, ST_RUN: begin
        // An IDLE cycle with start high behaves as a RUN cycle so the
        // first fetch lands on the same edge that enters RUN.
        if (!start_i) begin
          state_next = ST_IDLE;
          if (state == ST_RUN && stall_i) ifid_op = IFID_HOLD;
        end else if (redirect_i) begin
          state_next = ST_RUN;
          pc_load    = 1'b1;
        end else if (stall_i) begin
          state_next = ST_RUN;
          ifid_op    = IFID_HOLD;
        end else if (!pc_in_space) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_RUN;
          ifid_op    = IFID_LOAD;
          pc_incr    = 1'b1;
          count_inc  = 1'b1;
        end
      end
      ST_HALT: begin
        if (redirect_i && tgt_in_space) begin
          state_next = ST_RUN;
          pc_load    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // IF/ID pipeline register and accepted-instruction counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_id_pc4_o   <= '0;
      if_id_inst_o  <= PC_W'(NOP_INST);
      if_id_valid_o <= 1'b0;
      fetch_count_o <= '0;
    end else begin
      unique case (ifid_op)
        IFID_LOAD: begin
          if_id_pc4_o   <= pc_plus4;
          if_id_inst_o  <= imem_data_i;
          if_id_valid_o <= 1'b1;
        end
        IFID_BUBBLE: begin
          if_id_pc4_o   <= '0;
          if_id_inst_o  <= PC_W'(NOP_INST);
          if_id_valid_o <= 1'b0;
        end
        default: ;
      endcase
      if (count_inc) fetch_count_o <= fetch_count_o + PC_W'(1);
    end
  end

  assign pc_o        = pc;
  assign imem_addr_o = pc;
  assign halted_o    = (state == ST_HALT);

endmodule
